// File: rtl/uart_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_arbiter_if
//
// Bundles the two signal groups of the UART arbiter:
//   - per-thread request side (thr_*): requests from the core's hardware
//     threads and the completion/return path back to them;
//   - MMIO side (mmio_*): a simple req/ack register bus to the UART slave.
//
// Modports:
//   master : the arbiter's view (takes thread requests, masters the MMIO bus)
//   slave  : the environment's view (threads + UART register slave)
//
// Signals:
//   thr_req    [NUM_THREADS]   per-thread request, held until thr_done
//   thr_op     [NUM_THREADS]   0 = read byte, 1 = write byte
//   thr_wdata  [8*NUM_THREADS] write byte of thread i at [8i+7:8i]
//   thr_done   [NUM_THREADS]   one-hot, one-cycle completion pulse
//   thr_rdata  [8]             read byte, valid with thr_done
//   thr_err    [1]             timeout flag, valid with thr_done
//   mmio_req / mmio_we / mmio_addr[2] / mmio_wdata[8]  access request
//   mmio_rdata[8] / mmio_ack   access response
// ---------------------------------------------------------------------------
interface uart_arbiter_if #(
    parameter int NUM_THREADS = 4
);
    logic [NUM_THREADS-1:0]   thr_req;
    logic [NUM_THREADS-1:0]   thr_op;
    logic [8*NUM_THREADS-1:0] thr_wdata;
    logic [NUM_THREADS-1:0]   thr_done;
    logic [7:0]               thr_rdata;
    logic                     thr_err;

    logic                     mmio_req;
    logic                     mmio_we;
    logic [1:0]               mmio_addr;
    logic [7:0]               mmio_wdata;
    logic [7:0]               mmio_rdata;
    logic                     mmio_ack;

    modport master (
        input  thr_req, thr_op, thr_wdata, mmio_rdata, mmio_ack,
        output thr_done, thr_rdata, thr_err,
               mmio_req, mmio_we, mmio_addr, mmio_wdata
    );

    modport slave (
        output thr_req, thr_op, thr_wdata, mmio_rdata, mmio_ack,
        input  thr_done, thr_rdata, thr_err,
               mmio_req, mmio_we, mmio_addr, mmio_wdata
    );
endinterface

// File: rtl/uart_arbiter.sv
// ---------------------------------------------------------------------------
// uart_arbiter
//
// Shares the single memory-mapped host UART among NUM_THREADS hardware
// threads. One thread is granted at a time in round-robin order and the
// arbiter then runs the full flag handshake on the UART byte registers:
//   read : poll rd-valid (0x01) until bit0 = 1, read rd data (0x00),
//          write 0x00 to rd-valid;
//   write: poll wr-to-host (0x03) until bit0 = 0, write wr data (0x02),
//          write 0x01 to wr-to-host.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : uart_arbiter_if.master (thread request side + MMIO master side)
//
// Parameters:
//   NUM_THREADS : number of requesting threads (2..8)
//   POLL_LIMIT  : polls per operation before timeout (timeout build only)
//
// Build option:
//   UART_ARB_TIMEOUT_EN : when defined, a flag poll that is still not ready
//   on poll number POLL_LIMIT ends the operation with thr_err = 1 and
//   thr_rdata = 0. When undefined, polling continues indefinitely and
//   thr_err stays 0.
// ---------------------------------------------------------------------------
module uart_arbiter #(
    parameter int NUM_THREADS = 4,
    parameter int POLL_LIMIT  = 255
) (
    input  logic           clk,
    input  logic           rst,
    uart_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    localparam logic [1:0] ADDR_RD_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RD_VALID   = 2'd1;
    localparam logic [1:0] ADDR_WR_DATA    = 2'd2;
    localparam logic [1:0] ADDR_WR_TO_HOST = 2'd3;

    localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT - 1);

`ifdef UART_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_POLL = 3'd1,
        RD_DATA = 3'd2,
        RD_CLR  = 3'd3,
        WR_POLL = 3'd4,
        WR_DATA = 3'd5,
        WR_SET  = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_op;
    logic [7:0]             win_wdata;
    logic [7:0]             rd_byte;
    logic [7:0]             poll_cnt;

    logic                   mmio_req_r;
    logic                   mmio_we_r;
    logic [1:0]             mmio_addr_r;
    logic [7:0]             mmio_wdata_r;

    logic [NUM_THREADS-1:0] done_r;
    logic [7:0]             rdata_r;
    logic                   err_r;

    logic [IDX_W-1:0]       pick_idx;
    logic                   poll_timeout;
    logic                   acc_we;
    logic [1:0]             acc_addr;
    logic [7:0]             acc_wdata;

    // First requesting thread at or after ptr, wrapping modulo NUM_THREADS.
    // Scanning from the far end lets the closest candidate overwrite.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_THREADS-1:0] req,
        input logic [IDX_W-1:0]       ptr
    );
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = ptr;
        for (int k = NUM_THREADS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_THREADS;
            if (req[IDX_W'(idx)]) begin
                pick = IDX_W'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return IDX_W'((int'(i) + 1) % NUM_THREADS);
    endfunction

    function automatic logic [7:0] byte_of(
        input logic [8*NUM_THREADS-1:0] v,
        input logic [IDX_W-1:0]         i
    );
        logic [7:0] b;
        b = 8'h00;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (IDX_W'(t) == i) begin
                b = v[8*t +: 8];
            end
        end
        return b;
    endfunction

    function automatic logic [NUM_THREADS-1:0] onehot(input logic [IDX_W-1:0] i);
        return NUM_THREADS'(1) << i;
    endfunction

    // Poll counter saturates instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign pick_idx     = rr_pick(bus.thr_req, rr_ptr);
    assign poll_timeout = TIMEOUT_EN && (poll_cnt == POLL_LAST);

    // Register access that belongs to each handshake step.
    always_comb begin
        acc_we    = 1'b0;
        acc_addr  = ADDR_RD_VALID;
        acc_wdata = 8'h00;
        case (state)
            RD_POLL: begin
                acc_addr = ADDR_RD_VALID;
            end
            RD_DATA: begin
                acc_addr = ADDR_RD_DATA;
            end
            RD_CLR: begin
                acc_we    = 1'b1;
                acc_addr  = ADDR_RD_VALID;
                acc_wdata = 8'h00;
            end
            WR_POLL: begin
                acc_addr = ADDR_WR_TO_HOST;
            end
            WR_DATA: begin
                acc_we    = 1'b1;
                acc_addr  = ADDR_WR_DATA;
                acc_wdata = win_wdata;
            end
            WR_SET: begin
                acc_we    = 1'b1;
                acc_addr  = ADDR_WR_TO_HOST;
                acc_wdata = 8'h01;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            win_idx      <= '0;
            win_op       <= 1'b0;
            win_wdata    <= 8'h00;
            rd_byte      <= 8'h00;
            poll_cnt     <= 8'h00;
            mmio_req_r   <= 1'b0;
            mmio_we_r    <= 1'b0;
            mmio_addr_r  <= 2'd0;
            mmio_wdata_r <= 8'h00;
            done_r       <= '0;
            rdata_r      <= 8'h00;
            err_r        <= 1'b0;
        end else begin
            done_r <= '0;
            case (state)
                IDLE: begin
                    if (|bus.thr_req) begin
                        win_idx   <= pick_idx;
                        win_op    <= bus.thr_op[pick_idx];
                        win_wdata <= byte_of(bus.thr_wdata, pick_idx);
                        rr_ptr    <= next_idx(pick_idx);
                        state     <= bus.thr_op[pick_idx] ? WR_POLL : RD_POLL;
                    end
                end

                // thr_done/rdata/err were loaded on entry, so they are
                // visible exactly for this one cycle.
                DONE: begin
                    rdata_r  <= 8'h00;
                    err_r    <= 1'b0;
                    poll_cnt <= 8'h00;
                    state    <= IDLE;
                end

                default: begin
                    // Request is low for at least one cycle between accesses:
                    // it drops at the ack edge and is re-raised one edge later.
                    if (!mmio_req_r) begin
                        mmio_req_r   <= 1'b1;
                        mmio_we_r    <= acc_we;
                        mmio_addr_r  <= acc_addr;
                        mmio_wdata_r <= acc_wdata;
                    end else if (bus.mmio_ack) begin
                        mmio_req_r <= 1'b0;
                        case (state)
                            RD_POLL: begin
                                if (bus.mmio_rdata[0]) begin
                                    state <= RD_DATA;
                                end else if (poll_timeout) begin
                                    done_r  <= onehot(win_idx);
                                    rdata_r <= 8'h00;
                                    err_r   <= 1'b1;
                                    state   <= DONE;
                                end else begin
                                    poll_cnt <= sat_inc(poll_cnt);
                                end
                            end
                            RD_DATA: begin
                                rd_byte <= bus.mmio_rdata;
                                state   <= RD_CLR;
                            end
                            WR_POLL: begin
                                if (!bus.mmio_rdata[0]) begin
                                    state <= WR_DATA;
                                end else if (poll_timeout) begin
                                    done_r  <= onehot(win_idx);
                                    rdata_r <= 8'h00;
                                    err_r   <= 1'b1;
                                    state   <= DONE;
                                end else begin
                                    poll_cnt <= sat_inc(poll_cnt);
                                end
                            end
                            WR_DATA: begin
                                state <= WR_SET;
                            end
                            RD_CLR, WR_SET: begin
                                done_r  <= onehot(win_idx);
                                rdata_r <= win_op ? 8'h00 : rd_byte;
                                err_r   <= 1'b0;
                                state   <= DONE;
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.mmio_req   = mmio_req_r;
    assign bus.mmio_we    = mmio_we_r;
    assign bus.mmio_addr  = mmio_addr_r;
    assign bus.mmio_wdata = mmio_wdata_r;
    assign bus.thr_done   = done_r;
    assign bus.thr_rdata  = rdata_r;
    assign bus.thr_err    = err_r;

endmodule

// File: tb/tb_uart_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_arbiter
//
// Directed bench for uart_arbiter (NUM_THREADS = 4, POLL_LIMIT = 4). A small
// UART register model answers MMIO accesses after a programmable delay,
// logs every acknowledged access and every thr_done pulse; each scenario
// task then compares the logs with hand-derived expectations.
// Honours UART_ARB_TIMEOUT_EN for the poll-timeout scenario.
// ---------------------------------------------------------------------------
module tb_uart_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_arbiter_if #(.NUM_THREADS(4)) bus ();

    uart_arbiter #(
        .NUM_THREADS(4),
        .POLL_LIMIT (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // UART register model and responder controls
    logic [7:0] uart_reg [4];
    int         ack_delay     = 1;
    int         busy_left     = 0;
    bit         sticky        = 1'b0;
    bit         stray_pending = 1'b0;
    int         wait_cnt      = 0;
    int         stab_err      = 0;
    int         hold_last     = 0;
    logic       cap_we;
    logic [1:0] cap_addr;
    logic [7:0] cap_wdata;

    // access log
    logic       acc_we   [64];
    logic [1:0] acc_addr [64];
    logic [7:0] acc_wd   [64];
    int         acc_cnt = 0;

    // done log
    logic [3:0] done_val [16];
    logic [7:0] done_rd  [16];
    logic       done_err [16];
    int         done_cnt = 0;

    // UART slave + done monitor, sampling 1 time unit after each edge
    initial begin
        bus.mmio_ack   = 1'b0;
        bus.mmio_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (bus.thr_done !== 4'b0000) begin
                if (done_cnt < 16) begin
                    done_val[done_cnt] = bus.thr_done;
                    done_rd[done_cnt]  = bus.thr_rdata;
                    done_err[done_cnt] = bus.thr_err;
                end
                done_cnt++;
            end
            if (bus.mmio_ack) begin
                bus.mmio_ack   = 1'b0;
                bus.mmio_rdata = 8'h00;
            end else if (stray_pending) begin
                bus.mmio_ack   = 1'b1;
                bus.mmio_rdata = 8'hFF;
                stray_pending  = 1'b0;
            end else if (bus.mmio_req) begin
                if (wait_cnt == 0) begin
                    cap_we    = bus.mmio_we;
                    cap_addr  = bus.mmio_addr;
                    cap_wdata = bus.mmio_wdata;
                end else if (cap_we !== bus.mmio_we || cap_addr !== bus.mmio_addr ||
                             cap_wdata !== bus.mmio_wdata) begin
                    stab_err++;
                end
                if (wait_cnt >= ack_delay) begin
                    if (bus.mmio_we) begin
                        if (!(sticky && (bus.mmio_addr == 2'd1 || bus.mmio_addr == 2'd3)))
                            uart_reg[bus.mmio_addr] = bus.mmio_wdata;
                        bus.mmio_rdata = 8'h00;
                    end else if (bus.mmio_addr == 2'd3 && busy_left > 0) begin
                        bus.mmio_rdata = 8'h01;
                        busy_left--;
                    end else begin
                        bus.mmio_rdata = uart_reg[bus.mmio_addr];
                    end
                    if (acc_cnt < 64) begin
                        acc_we[acc_cnt]   = bus.mmio_we;
                        acc_addr[acc_cnt] = bus.mmio_addr;
                        acc_wd[acc_cnt]   = bus.mmio_wdata;
                    end
                    acc_cnt++;
                    bus.mmio_ack = 1'b1;
                    hold_last    = wait_cnt;
                    wait_cnt     = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst           = 1'b1;
        bus.thr_req   = 4'b0000;
        bus.thr_op    = 4'b0000;
        bus.thr_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        rst       = 1'b0;
        ack_delay = 1;
        busy_left = 0;
        sticky    = 1'b0;
        stab_err  = 0;
        acc_cnt   = 0;
        for (int i = 0; i < 4; i++) uart_reg[i] = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.mmio_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mmio_req: got %b want 0", bus.mmio_req);
        end
        vectors++;
        if ({bus.mmio_we, bus.mmio_addr, bus.mmio_wdata} !== 11'h000) begin
            miscompares++;
            $display("FAIL rst_mmio_bus: got %h want 000", {bus.mmio_we, bus.mmio_addr, bus.mmio_wdata});
        end
        vectors++;
        if ({bus.thr_done, bus.thr_rdata, bus.thr_err} !== 13'h0000) begin
            miscompares++;
            $display("FAIL rst_thr_out: got %h want 0000", {bus.thr_done, bus.thr_rdata, bus.thr_err});
        end
    endtask

    task automatic test_single_read();
        int start;
        int guard;
        do_reset();
        uart_reg[1] = 8'h01;
        uart_reg[0] = 8'h5A;
        start       = done_cnt;
        bus.thr_req = 4'b0001;
        guard       = 0;
        while (done_cnt == start && guard < 200) begin
            @(posedge clk); #2; guard++;
        end
        bus.thr_req = 4'b0000;
        repeat (4) @(posedge clk);
        #2;
        vectors++;
        if (done_cnt != start + 1) begin
            miscompares++;
            $display("FAIL rd_done_count: got %0d want 1", done_cnt - start);
        end
        vectors++;
        if (acc_cnt != 3) begin
            miscompares++;
            $display("FAIL rd_acc_count: got %0d want 3", acc_cnt);
        end
        vectors++;
        if ({acc_we[0], acc_addr[0], acc_we[1], acc_addr[1]} !== 6'b0_01_0_00) begin
            miscompares++;
            $display("FAIL rd_acc_poll_data: got %b want 001000", {acc_we[0], acc_addr[0], acc_we[1], acc_addr[1]});
        end
        vectors++;
        if ({acc_we[2], acc_addr[2], acc_wd[2]} !== {1'b1, 2'd1, 8'h00}) begin
            miscompares++;
            $display("FAIL rd_acc_clear: got %h want 300", {acc_we[2], acc_addr[2], acc_wd[2]});
        end
        vectors++;
        if ({done_val[start], done_rd[start], done_err[start]} !== {4'b0001, 8'h5A, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_done: got %b/%h/%b want 0001/5a/0", done_val[start], done_rd[start], done_err[start]);
        end
        vectors++;
        if (uart_reg[1] !== 8'h00) begin
            miscompares++;
            $display("FAIL rd_valid_cleared: got %h want 00", uart_reg[1]);
        end
    endtask

    task automatic test_write();
        int start;
        int guard;
        do_reset();
        uart_reg[3]   = 8'h00;
        busy_left     = 2;
        start         = done_cnt;
        bus.thr_wdata = 32'h11C3_2244;
        bus.thr_op    = 4'b0100;
        bus.thr_req   = 4'b0100;
        guard         = 0;
        while (done_cnt == start && guard < 300) begin
            @(posedge clk); #2; guard++;
        end
        bus.thr_req = 4'b0000;
        repeat (4) @(posedge clk);
        #2;
        vectors++;
        if (acc_cnt != 5) begin
            miscompares++;
            $display("FAIL wr_acc_count: got %0d want 5", acc_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({acc_we[i], acc_addr[i]} !== 3'b0_11) begin
                miscompares++;
                $display("FAIL wr_poll_%0d: got %b want 011", i, {acc_we[i], acc_addr[i]});
            end
        end
        vectors++;
        if ({acc_we[3], acc_addr[3], acc_wd[3]} !== {1'b1, 2'd2, 8'hC3}) begin
            miscompares++;
            $display("FAIL wr_data: got %h want 2c3", {acc_we[3], acc_addr[3], acc_wd[3]});
        end
        vectors++;
        if ({acc_we[4], acc_addr[4], acc_wd[4]} !== {1'b1, 2'd3, 8'h01}) begin
            miscompares++;
            $display("FAIL wr_set: got %h want 301", {acc_we[4], acc_addr[4], acc_wd[4]});
        end
        vectors++;
        if ({done_val[start], done_rd[start], done_err[start]} !== {4'b0100, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL wr_done: got %b/%h/%b want 0100/00/0", done_val[start], done_rd[start], done_err[start]);
        end
    endtask

    task automatic test_round_robin();
        int         start;
        int         guard;
        logic [3:0] exp_rr [5];
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        sticky      = 1'b1;
        uart_reg[1] = 8'h01;
        uart_reg[0] = 8'h42;
        start       = done_cnt;
        bus.thr_op  = 4'b0000;
        bus.thr_req = 4'b1111;
        guard       = 0;
        while (done_cnt < start + 5 && guard < 600) begin
            @(posedge clk); #2; guard++;
        end
        bus.thr_req = 4'b0000;
        repeat (4) @(posedge clk);
        #2;
        vectors++;
        if (done_cnt != start + 5) begin
            miscompares++;
            $display("FAIL rr_done_count: got %0d want 5", done_cnt - start);
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({done_val[start+i], done_rd[start+i]} !== {exp_rr[i], 8'h42}) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: got %b/%h want %b/42", i, done_val[start+i], done_rd[start+i], exp_rr[i]);
            end
        end
    endtask

    task automatic test_delayed_ack();
        int start;
        int guard;
        do_reset();
        ack_delay     = 5;
        bus.thr_wdata = 32'h3C00_0000;
        bus.thr_op    = 4'b1000;
        bus.thr_req   = 4'b1000;
        start         = done_cnt;
        guard         = 0;
        while (done_cnt == start && guard < 300) begin
            @(posedge clk); #2; guard++;
        end
        bus.thr_req = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (stab_err != 0) begin
            miscompares++;
            $display("FAIL dly_stable: got %0d changes want 0", stab_err);
        end
        vectors++;
        if (hold_last != 5) begin
            miscompares++;
            $display("FAIL dly_hold: got %0d cycles want 5", hold_last);
        end
        vectors++;
        if ({acc_cnt[3:0], acc_wd[1], done_val[start]} !== {4'd3, 8'h3C, 4'b1000}) begin
            miscompares++;
            $display("FAIL dly_write: got cnt %0d data %h done %b want 3/3c/1000", acc_cnt, acc_wd[1], done_val[start]);
        end
        // stray ack while idle
        ack_delay     = 1;
        acc_cnt       = 0;
        start         = done_cnt;
        stray_pending = 1'b1;
        repeat (4) begin
            @(posedge clk); #2;
            vectors++;
            if (bus.mmio_req !== 1'b0 || done_cnt != start) begin
                miscompares++;
                $display("FAIL stray_idle: got req %b dones %0d want 0/0", bus.mmio_req, done_cnt - start);
            end
        end
        uart_reg[1] = 8'h01;
        uart_reg[0] = 8'h66;
        bus.thr_op  = 4'b0000;
        bus.thr_req = 4'b0010;
        guard       = 0;
        while (done_cnt == start && guard < 200) begin
            @(posedge clk); #2; guard++;
        end
        bus.thr_req = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if ({acc_cnt[3:0], acc_addr[0], done_val[start], done_rd[start]} !== {4'd3, 2'd1, 4'b0010, 8'h66}) begin
            miscompares++;
            $display("FAIL stray_after: got cnt %0d addr %0d done %b rd %h want 3/1/0010/66", acc_cnt, acc_addr[0], done_val[start], done_rd[start]);
        end
    endtask

    task automatic test_reset_mid_op();
        int start;
        int guard;
        do_reset();
        ack_delay     = 3;
        bus.thr_wdata = 32'h0000_0077;
        bus.thr_op    = 4'b0001;
        bus.thr_req   = 4'b0001;
        guard         = 0;
        while (!(bus.mmio_req === 1'b1 && bus.mmio_we === 1'b1 && bus.mmio_addr === 2'd2) && guard < 200) begin
            @(posedge clk); #2; guard++;
        end
        vectors++;
        if (!(bus.mmio_req === 1'b1 && bus.mmio_addr === 2'd2)) begin
            miscompares++;
            $display("FAIL mid_reach_wr_data: got req %b addr %0d want 1/2", bus.mmio_req, bus.mmio_addr);
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst         = 1'b0;
        bus.thr_req = 4'b0000;
        vectors++;
        if (bus.mmio_req !== 1'b0 || bus.thr_done !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset_req: got req %b done %b want 0/0000", bus.mmio_req, bus.thr_done);
        end
        repeat (3) begin
            @(posedge clk); #2;
            vectors++;
            if (bus.mmio_req !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_idle: got req %b want 0", bus.mmio_req);
            end
        end
        ack_delay   = 1;
        acc_cnt     = 0;
        uart_reg[1] = 8'h01;
        uart_reg[0] = 8'h21;
        start       = done_cnt;
        bus.thr_op  = 4'b0000;
        bus.thr_req = 4'b0010;
        guard       = 0;
        while (done_cnt == start && guard < 200) begin
            @(posedge clk); #2; guard++;
        end
        bus.thr_req = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if ({acc_cnt[3:0], done_val[start], done_rd[start], done_err[start]} !== {4'd3, 4'b0010, 8'h21, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_regrant: got cnt %0d done %b rd %h err %b want 3/0010/21/0", acc_cnt, done_val[start], done_rd[start], done_err[start]);
        end
    endtask

    task automatic test_timeout();
        int start;
        int guard;
        int other;
        do_reset();
        uart_reg[1] = 8'h00;
        uart_reg[0] = 8'h99;
        start       = done_cnt;
        bus.thr_op  = 4'b0000;
        bus.thr_req = 4'b0001;
`ifdef UART_ARB_TIMEOUT_EN
        guard = 0;
        while (done_cnt == start && guard < 200) begin
            @(posedge clk); #2; guard++;
        end
        bus.thr_req = 4'b0000;
        repeat (4) @(posedge clk);
        #2;
        other = 0;
        for (int i = 0; i < acc_cnt && i < 64; i++)
            if (acc_we[i] !== 1'b0 || acc_addr[i] !== 2'd1) other++;
        vectors++;
        if (acc_cnt != 4 || other != 0) begin
            miscompares++;
            $display("FAIL to_polls: got %0d accesses (%0d not rd 0x01) want 4/0", acc_cnt, other);
        end
        vectors++;
        if ({done_val[start], done_rd[start], done_err[start]} !== {4'b0001, 8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL to_done: got %b/%h/%b want 0001/00/1", done_val[start], done_rd[start], done_err[start]);
        end
`else
        repeat (60) @(posedge clk);
        #2;
        other = 0;
        for (int i = 0; i < acc_cnt && i < 64; i++)
            if (acc_we[i] !== 1'b0 || acc_addr[i] !== 2'd1) other++;
        vectors++;
        if (done_cnt != start || acc_cnt < 10 || other != 0) begin
            miscompares++;
            $display("FAIL poll_forever: got dones %0d polls %0d other %0d want 0/>=10/0", done_cnt - start, acc_cnt, other);
        end
        uart_reg[1] = 8'h01;
        guard       = 0;
        while (done_cnt == start && guard < 200) begin
            @(posedge clk); #2; guard++;
        end
        bus.thr_req = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if ({done_val[start], done_rd[start], done_err[start]} !== {4'b0001, 8'h99, 1'b0}) begin
            miscompares++;
            $display("FAIL poll_release: got %b/%h/%b want 0001/99/0", done_val[start], done_rd[start], done_err[start]);
        end
`endif
    endtask

    initial begin
        bus.thr_req   = 4'b0000;
        bus.thr_op    = 4'b0000;
        bus.thr_wdata = 32'h0;
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_delayed_ack();
        test_reset_mid_op();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_arbiter.md
Name: uart_arbiter

Overview:
- Shares the single memory-mapped host UART among NUM_THREADS hardware threads.
- Grants one thread at a time, round-robin.
- Runs the full register handshake on the UART's four byte registers:
  - read: poll rd-valid (0x01), take rd data (0x00), clear rd-valid;
  - write: poll wr-to-host (0x03) until clear, write wr data (0x02), set wr-to-host.
- Sits between the per-thread I/O request ports of the core and the UART MMIO slave.

Parameters:
- NUM_THREADS, 4, number of requesting threads (2..8).
- POLL_LIMIT, 255, maximum flag polls per operation before timeout (only with timeout feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- thr_req  in  NUM_THREADS  per-thread request, held high until thr_done
- thr_op  in  NUM_THREADS  per-thread op: 0 = read byte, 1 = write byte
- thr_wdata  in  8*NUM_THREADS  per-thread write byte, thread i at [8i+7:8i]
- thr_done  out  NUM_THREADS  one-hot, one-cycle completion pulse
- thr_rdata  out  8  read byte, valid in the thr_done cycle
- thr_err  out  1  timeout flag, valid in the thr_done cycle
- mmio_req  out  1  UART access request
- mmio_we  out  1  1 = write, 0 = read
- mmio_addr  out  2  UART register address
- mmio_wdata  out  8  UART write data
- mmio_rdata  in  8  UART read data, valid with mmio_ack
- mmio_ack  in  1  one-cycle access acknowledge

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - round-robin pointer 0;
  - poll counter 0;
  - latched thread/op/data cleared.
- MMIO handshake:
  - mmio_req, mmio_we, mmio_addr and mmio_wdata are registered and held stable until the cycle mmio_ack is seen.
  - mmio_req drops the cycle after the ack.
  - The next access starts no earlier than one cycle after that.
  - An ack while mmio_req is low is ignored.
- IDLE:
  - If any thr_req is set, pick the first set bit at or after the pointer, wrapping modulo NUM_THREADS.
  - Latch the winner's index, op and wdata; set pointer = winner+1 mod NUM_THREADS.
  - Go to RD_POLL (op 0) or WR_POLL (op 1).
  - Arbitration takes 1 cycle.
- RD_POLL: read 0x01. On ack: if bit0 = 1 go to RD_DATA, else increment the poll counter and re-poll.
- RD_DATA: read 0x00. On ack, latch rdata and go to RD_CLR.
- RD_CLR: write 0x00 to 0x01. On ack go to DONE.
- WR_POLL: read 0x03. On ack: if bit0 = 0 go to WR_DATA, else increment the poll counter and re-poll.
- WR_DATA: write the latched byte to 0x02. On ack go to WR_SET.
- WR_SET: write 0x01 to 0x03. On ack go to DONE.
- DONE:
  - Pulse thr_done[winner] for 1 cycle, with thr_rdata (reads; 0 for writes) and thr_err.
  - Clear the poll counter and return to IDLE.
- Request rules:
  - A thread still holding thr_req after its done pulse is re-arbitrated behind the others because the pointer has advanced.
  - thr_req falling mid-operation is ignored; the operation completes and done still pulses.
  - thr_op and thr_wdata are sampled only at arbitration.
- Simultaneous requests: exactly one grant; the lowest index at or after the pointer wins.
- Reset mid-operation: returns to IDLE next edge and mmio_req drops. A UART flag left partially updated is not repaired.
- Poll counter is 8 bits and saturates at 255.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - In RD_POLL or WR_POLL, when a poll ack arrives with the flag not ready and the counter equals POLL_LIMIT-1, go to DONE with thr_err = 1 and thr_rdata = 0.
  - No data, clear or set access is issued.
- Undefined:
  - Polling continues indefinitely.
  - thr_err is tied 0.

Test Plan:
- Single read, UART rd-valid already 1 and rd data 0x5A, ack 1 cycle after each req:
  - accesses are rd 0x01, rd 0x00, wr 0x01 = 0x00;
  - thr_done = 0001 with thr_rdata = 0x5A, thr_err = 0.
- Write 0xC3 from thread 2, wr-to-host reads 1 twice then 0:
  - accesses are three rd 0x03, wr 0x02 = 0xC3, wr 0x03 = 0x01;
  - thr_done = 0100.
- All four threads request simultaneously from reset and hold requests:
  - grant order 0,1,2,3,0;
  - no two done pulses in the same cycle.
- Ack delayed 5 cycles:
  - mmio_req, mmio_addr and mmio_wdata stay stable for all 5 cycles;
  - a stray ack while idle produces no state change.
- Reset asserted during WR_DATA:
  - next cycle mmio_req = 0 and state is IDLE;
  - a subsequent request from thread 1 is granted normally.
- With UART_ARB_TIMEOUT_EN and POLL_LIMIT = 4, rd-valid stuck at 0:
  - exactly 4 polls of 0x01;
  - thr_done pulses with thr_err = 1 and thr_rdata = 0x00;
  - no access to 0x00.
